// File: rtl/bar_pkg.sv
// Shared constants and types for the spectrum bar pipeline (level generator and renderer).
package bar_pkg;

  localparam int NUM_BARS      = 10;
  localparam int HEIGHT_W      = 10;
  localparam int BINS_PER_BAND = 4;
  localparam int MAG_W         = 16;
  localparam int MAG_SHIFT     = 6;
  localparam int MAX_HEIGHT    = 479;
  localparam int DECAY_STEP    = 4;
  localparam int HOLD_FRAMES   = 30;

  localparam int NUM_BINS  = NUM_BARS * BINS_PER_BAND;
  localparam int BIN_CNT_W = $clog2(NUM_BINS + 1);
  localparam int HOLD_W    = $clog2(HOLD_FRAMES + 1);

  typedef logic [HEIGHT_W-1:0] height_t;
  typedef logic [MAG_W-1:0]    mag_t;

  // Shift at full magnitude width first so large bins clamp instead of wrapping.
  function automatic height_t scale_mag(input mag_t m);
    mag_t s;
    s = m >> MAG_SHIFT;
    if (s > mag_t'(MAX_HEIGHT)) return height_t'(MAX_HEIGHT);
    else                        return s[HEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/bar_channel.sv
// One bar: committed target, frame-synchronous attack/decay height and,
// with BAR_PEAK_HOLD_EN defined, a peak marker with hold timer.
module bar_channel
  import bar_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    tick,
  input  logic    commit,
  input  height_t target_in,
  output height_t height
`ifdef BAR_PEAK_HOLD_EN
  ,
  output height_t peak
`endif
);

  height_t target;
  height_t height_dec;
  height_t height_next;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    height_dec  = (height > height_t'(DECAY_STEP)) ? height - height_t'(DECAY_STEP) : '0;
    height_next = target;
    if (target <= height && height_dec > target) height_next = height_dec;
  end

  // NOTE: non-blocking updates mean a tick in the commit cycle still sees the old target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
      height <= '0;
    end else begin
      if (commit) target <= target_in;
      if (tick)   height <= height_next;
    end
  end

`ifdef BAR_PEAK_HOLD_EN
  logic [HOLD_W-1:0] hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
      hold <= '0;
    end else if (tick) begin
      if (height_next >= peak) begin
        peak <= height_next;
        hold <= HOLD_W'(HOLD_FRAMES);
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
      end else begin
        // peak > height_next here, so one step down never passes below it
        peak <= peak - 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/bar_level_gen.sv
// Groups spectral bins into bands, keeps per-band peaks and drives smoothed bar heights.
// Optional peak markers are built when BAR_PEAK_HOLD_EN is defined.
module bar_level_gen
  import bar_pkg::*;
(
  input  logic                         MAX10_CLK1_50,
  input  logic                         Reset_h,
  input  logic                         mag_valid,
  input  logic [MAG_W-1:0]             mag_data,
  input  logic                         mag_last,
  input  logic                         VGA_VS,
  output logic [NUM_BARS*HEIGHT_W-1:0] bar_height
`ifdef BAR_PEAK_HOLD_EN
  ,
  output logic [NUM_BARS*HEIGHT_W-1:0] peak_height
`endif
);

  logic [BIN_CNT_W-1:0] bin_cnt;
  logic [BIN_CNT_W-1:0] band;
  logic                 in_range;
  logic                 commit;
  logic                 vs_q;
  logic                 tick;

  mag_t    stage      [NUM_BARS];
  mag_t    stage_fold [NUM_BARS];
  height_t target_new [NUM_BARS];

  assign in_range = bin_cnt < BIN_CNT_W'(NUM_BINS);
  assign band     = bin_cnt / BIN_CNT_W'(BINS_PER_BAND);
  assign commit   = mag_valid & mag_last;

  // The current beat is folded in before the commit snapshot is scaled.
  always_comb begin
    for (int i = 0; i < NUM_BARS; i++) begin
      stage_fold[i] = stage[i];
      if (mag_valid && in_range && band == BIN_CNT_W'(i) && mag_data > stage[i])
        stage_fold[i] = mag_data;
      target_new[i] = scale_mag(stage_fold[i]);
    end
  end

  // NOTE: the staging array is small and must start from zero, so it is reset like any register.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      bin_cnt <= '0;
      for (int i = 0; i < NUM_BARS; i++) stage[i] <= '0;
    end else if (commit) begin
      bin_cnt <= '0;
      for (int i = 0; i < NUM_BARS; i++) stage[i] <= '0;
    end else if (mag_valid && in_range) begin
      bin_cnt <= bin_cnt + 1'b1;
      for (int i = 0; i < NUM_BARS; i++) stage[i] <= stage_fold[i];
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      vs_q <= 1'b0;
      tick <= 1'b0;
    end else begin
      vs_q <= VGA_VS;
      tick <= VGA_VS & ~vs_q;
    end
  end

  for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
    bar_channel u_channel (
      .clk       (MAX10_CLK1_50),
      .rst       (Reset_h),
      .tick      (tick),
      .commit    (commit),
      .target_in (target_new[g]),
      .height    (bar_height[HEIGHT_W*g +: HEIGHT_W])
`ifdef BAR_PEAK_HOLD_EN
      ,
      .peak      (peak_height[HEIGHT_W*g +: HEIGHT_W])
`endif
    );
  end

endmodule

// File: tb/tb_bar_level_gen.sv
// Directed self-checking bench for bar_level_gen; peak-hold checks run when BAR_PEAK_HOLD_EN is defined.
module tb_bar_level_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        mag_valid;
  logic [15:0] mag_data;
  logic        mag_last;
  logic        vga_vs;
  logic [99:0] bar_height;
`ifdef BAR_PEAK_HOLD_EN
  logic [99:0] peak_height;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] spec_vals [10];

  always #5 clk = ~clk;

  bar_level_gen dut (
    .MAX10_CLK1_50 (clk),
    .Reset_h       (rst),
    .mag_valid     (mag_valid),
    .mag_data      (mag_data),
    .mag_last      (mag_last),
    .VGA_VS        (vga_vs),
    .bar_height    (bar_height)
`ifdef BAR_PEAK_HOLD_EN
    ,
    .peak_height   (peak_height)
`endif
  );

  function automatic logic [9:0] bar(input int i);
    return bar_height[i*10 +: 10];
  endfunction

`ifdef BAR_PEAK_HOLD_EN
  function automatic logic [9:0] pk(input int i);
    return peak_height[i*10 +: 10];
  endfunction
`endif

  // Called at posedge+1; presents one beat and returns at the next posedge+1.
  task automatic beat(input logic [15:0] d, input logic last);
    mag_valid = 1'b1;
    mag_data  = d;
    mag_last  = last;
    @(posedge clk); #1;
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    mag_data  = 16'h0;
  endtask

  // mode 0: normal 40 bins; 1: 40 bins then two out-of-range beats (0xFFFF, then last);
  // 2: 40 bins with VGA_VS raised so the tick lands on the commit cycle.
  task automatic send_spectrum(input int mode);
    for (int j = 0; j < 40; j++) begin
      if (mode == 2 && j == 38) vga_vs = 1'b1;
      beat((j % 4 == 2) ? spec_vals[j/4] : 16'h0, (mode != 1) && (j == 39));
    end
    if (mode == 1) begin
      beat(16'hFFFF, 1'b0);
      beat(16'h0000, 1'b1);
    end
    if (mode == 2) vga_vs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame_tick();
    vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vga_vs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; mag_valid = 1'b0; mag_data = 16'h0; mag_last = 1'b0; vga_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bar_height !== 100'h0) $display("FAIL reset_bars: got %h, expected 0", bar_height);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_attack();
    spec_vals = '{default: 16'h0};
    spec_vals[2] = 16'h1000;
    send_spectrum(0);
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (bar_height !== 100'h0) $display("FAIL attack_no_tick: got %h, expected 0", bar_height);
    else n_pass++;
    frame_tick();
    for (int i = 0; i < 10; i++)
      chk($sformatf("attack_bar%0d", i), bar(i), (i == 2) ? 10'd64 : 10'd0);
  endtask

  task automatic test_clamp_ignore();
    spec_vals = '{default: 16'h0};
    spec_vals[0] = 16'hFFFF;
    spec_vals[2] = 16'h1000;
    send_spectrum(1);
    frame_tick();
    chk("clamp_bar0", bar(0), 10'd479);
    chk("clamp_bar2", bar(2), 10'd64);
    chk("ignore_bar9", bar(9), 10'd0);
  endtask

  task automatic test_decay();
    spec_vals = '{default: 16'h0};
    send_spectrum(0);
    frame_tick(); chk("decay_t1_bar2", bar(2), 10'd60);
    frame_tick(); chk("decay_t2_bar2", bar(2), 10'd56);
    frame_tick(); chk("decay_t3_bar2", bar(2), 10'd52);
    repeat (13) frame_tick();
    chk("decay_floor_bar2", bar(2), 10'd0);
    frame_tick();
    chk("decay_stay_bar2", bar(2), 10'd0);
    chk("decay_t17_bar0", bar(0), 10'd411);
  endtask

  task automatic test_collision();
    spec_vals = '{default: 16'h0};
    spec_vals[5] = 16'h1900;
    send_spectrum(2);
    chk("collide_same_bar5", bar(5), 10'd0);
    chk("collide_same_bar0", bar(0), 10'd407);
    frame_tick();
    chk("collide_next_bar5", bar(5), 10'd100);
    chk("collide_next_bar0", bar(0), 10'd403);
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 20; j++) beat((j == 6) ? 16'hFFFF : 16'h0100, 1'b0);
    #3 rst = 1'b1;
    #1;
    n_total++;
    if (bar_height !== 100'h0) $display("FAIL midreset_bars: got %h, expected 0", bar_height);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    spec_vals = '{default: 16'h0};
    spec_vals[3] = 16'h0800;
    send_spectrum(0);
    frame_tick();
    chk("midreset_bar3", bar(3), 10'd32);
    chk("midreset_bar1", bar(1), 10'd0);
  endtask

`ifdef BAR_PEAK_HOLD_EN
  task automatic test_peak_hold();
    spec_vals = '{default: 16'h0};
    spec_vals[4] = 16'h3200;
    send_spectrum(0);
    frame_tick();
    chk("peak_set", pk(4), 10'd200);
    spec_vals = '{default: 16'h0};
    send_spectrum(0);
    repeat (30) frame_tick();
    chk("peak_held", pk(4), 10'd200);
    chk("peak_held_height", bar(4), 10'd80);
    frame_tick();
    chk("peak_fall1", pk(4), 10'd199);
    chk("peak_fall1_height", bar(4), 10'd76);
    frame_tick();
    chk("peak_fall2", pk(4), 10'd198);
  endtask
`endif

  initial begin
    test_reset();
    test_attack();
    test_clamp_ignore();
    test_decay();
    test_collision();
    test_reset_mid();
`ifdef BAR_PEAK_HOLD_EN
    test_peak_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
